// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel path.
//   mode_e       : per-frame pixel conversion mode
//   CSC_*        : BT.601-style 8-bit fixed-point colour conversion coefficients
//   CSC_OFFSET   : chroma offset (128 << 8) added before the >> 8
//   *_LSB        : byte lanes of a packed 24-bit pixel (R low, B high)
//   clamp_u8     : saturate an 18-bit signed fixed-point sum to an 8-bit code
package lcd_pkg;

    typedef enum logic [1:0] {
        MODE_RGB  = 2'd0,
        MODE_GRAY = 2'd1,
        MODE_YCC  = 2'd2,
        MODE_BIN  = 2'd3
    } mode_e;

    localparam int unsigned CSC_Y_R  = 77;
    localparam int unsigned CSC_Y_G  = 150;
    localparam int unsigned CSC_Y_B  = 29;
    localparam int unsigned CSC_CB_R = 43;
    localparam int unsigned CSC_CB_G = 85;
    localparam int unsigned CSC_CB_B = 128;
    localparam int unsigned CSC_CR_R = 128;
    localparam int unsigned CSC_CR_G = 107;
    localparam int unsigned CSC_CR_B = 21;
    localparam int unsigned CSC_OFFSET = 32768;

    localparam int R_LSB = 0;
    localparam int G_LSB = 8;
    localparam int B_LSB = 16;

    // Sum is value << 8; anything negative saturates to 0, anything past
    // 16 bits saturates to 255.
    function automatic logic [7:0] clamp_u8(input logic signed [17:0] s);
        logic [7:0] r;
        if (s < 0)
            r = 8'd0;
        else if (s > 18'sd65535)
            r = 8'd255;
        else
            r = s[15:8];
        return r;
    endfunction

endpackage

// File: rtl/picture_overlay_csc_rgb2ycbcr.sv
// Two-stage pipelined RGB888 -> YCbCr converter, fixed latency 2.
//   sys_clk : clock
//   rst     : synchronous active-high reset, clears both stages
//   rgb     : input pixel, R = [7:0], G = [15:8], B = [23:16]
//   y/cb/cr : converted components, valid 2 cycles after rgb
// Stage 1 registers the nine 16-bit unsigned products, stage 2 sums,
// shifts and clamps.
module rgb2ycbcr_pipe
    import lcd_pkg::*;
(
    input  logic        sys_clk,
    input  logic        rst,
    input  logic [23:0] rgb,
    output logic [7:0]  y,
    output logic [7:0]  cb,
    output logic [7:0]  cr
);

    logic [15:0] r16, g16, b16;
    logic [15:0] p_yr, p_yg, p_yb;
    logic [15:0] p_cbr, p_cbg, p_cbb;
    logic [15:0] p_crr, p_crg, p_crb;
    logic [15:0] y_sum;
    logic signed [17:0] cb_sum, cr_sum;

    assign r16 = {8'h00, rgb[R_LSB +: 8]};
    assign g16 = {8'h00, rgb[G_LSB +: 8]};
    assign b16 = {8'h00, rgb[B_LSB +: 8]};

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            p_yr  <= '0; p_yg  <= '0; p_yb  <= '0;
            p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
            p_crr <= '0; p_crg <= '0; p_crb <= '0;
        end else begin
            p_yr  <= r16 * 16'(CSC_Y_R);
            p_yg  <= g16 * 16'(CSC_Y_G);
            p_yb  <= b16 * 16'(CSC_Y_B);
            p_cbr <= r16 * 16'(CSC_CB_R);
            p_cbg <= g16 * 16'(CSC_CB_G);
            p_cbb <= b16 * 16'(CSC_CB_B);
            p_crr <= r16 * 16'(CSC_CR_R);
            p_crg <= g16 * 16'(CSC_CR_G);
            p_crb <= b16 * 16'(CSC_CR_B);
        end
    end

    // Luma coefficients sum to 256, so the 16-bit sum cannot overflow.
    assign y_sum  = p_yr + p_yg + p_yb;
    assign cb_sum = $signed({2'b00, p_cbb}) - $signed({2'b00, p_cbr})
                  - $signed({2'b00, p_cbg}) + $signed(18'(CSC_OFFSET));
    assign cr_sum = $signed({2'b00, p_crr}) - $signed({2'b00, p_crg})
                  - $signed({2'b00, p_crb}) + $signed(18'(CSC_OFFSET));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            y  <= '0;
            cb <= '0;
            cr <= '0;
        end else begin
            y  <= y_sum[15:8];
            cb <= clamp_u8(cb_sum);
            cr <= clamp_u8(cr_sum);
        end
    end

endmodule

// File: rtl/picture_overlay_csc.sv
// Picture overlay engine: places a PIC_W x PIC_H ROM picture at a
// frame-latched position, clips it at the screen edges, converts each ROM
// pixel (RGB / gray / YCbCr / binary) and outputs a stream delayed by
// L = ROM_LAT + 3 cycles, with BG_COLOR outside the picture.
//   sys_clk, rst          : clock, synchronous active-high reset
//   frame_start           : latches pos_x/pos_y/mode/thresh, restarts addressing
//   pix_de, screen_x/y    : incoming raster position
//   rom_addr, rom_en      : picture ROM read port
//   rom_data              : ROM pixel, ROM_LAT cycles after rom_en
//   pix_data_out          : output pixel
//   pix_de_out            : pix_de delayed by L
//   in_win_out            : pix_data_out carries picture content
// Stream semantics: there is no backpressure. pix_de is a pure valid
// qualifier; a pixel is consumed on every clock where pix_de is high, and
// pix_de_out/in_win_out qualify pix_data_out exactly L cycles later.
module picture_overlay_csc
    import lcd_pkg::*;
#(
    parameter int unsigned PIC_W    = 355,
    parameter int unsigned PIC_H    = 200,
    parameter int unsigned X_W      = 11,
    parameter int unsigned ADDR_W   = 17,
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [23:0] BG_COLOR = 24'h00FF00
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_de,
    input  logic [X_W-1:0]    screen_x,
    input  logic [X_W-1:0]    screen_y,
    input  logic [X_W-1:0]    pos_x,
    input  logic [X_W-1:0]    pos_y,
    input  logic [1:0]        mode,
    input  logic [7:0]        thresh,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [23:0]       rom_data,
    output logic [23:0]       pix_data_out,
    output logic              pix_de_out,
    output logic              in_win_out
);

    // Side-band delay from stage A to the output: ROM stage + CSC stages.
    localparam int D   = ROM_LAT + 2;
    localparam int CW  = X_W + 1;
    localparam int RCW = $clog2(PIC_H + 1);

    // Frame shadow state
    logic [X_W-1:0]    pos_x_s, pos_y_s;
    mode_e             mode_s;
    logic [7:0]        thresh_s;
    logic              armed;
    logic [ADDR_W-1:0] row_base;
    logic [RCW-1:0]    row_cnt;
    logic              line_hit;
    logic              de_d;

    // Values in force for the current pixel: frame_start wins over shadows
    logic [X_W-1:0]    eff_pos_x, eff_pos_y;
    mode_e             eff_mode;
    logic [7:0]        eff_thresh;
    logic              eff_armed;
    logic [ADDR_W-1:0] eff_row_base;

    logic [CW-1:0]     sx, sy, x_lo, x_hi, y_lo, y_hi;
    logic [X_W-1:0]    col;
    logic              in_win;
    logic              de_fall;

    always_comb begin
        eff_pos_x    = pos_x_s;
        eff_pos_y    = pos_y_s;
        eff_mode     = mode_s;
        eff_thresh   = thresh_s;
        eff_armed    = armed;
        eff_row_base = row_base;
        if (frame_start) begin
            eff_pos_x    = pos_x;
            eff_pos_y    = pos_y;
            eff_mode     = mode_e'(mode);
            eff_thresh   = thresh;
            eff_armed    = 1'b1;
            eff_row_base = '0;
        end
    end

    // One extra bit keeps a window hanging off the coordinate range from wrapping.
    assign sx   = {1'b0, screen_x};
    assign sy   = {1'b0, screen_y};
    assign x_lo = {1'b0, eff_pos_x};
    assign y_lo = {1'b0, eff_pos_y};
    assign x_hi = x_lo + CW'(PIC_W - 1);
    assign y_hi = y_lo + CW'(PIC_H - 1);
    assign col  = screen_x - eff_pos_x;

    assign in_win = eff_armed & pix_de
                  & (sy >= y_lo) & (sy <= y_hi)
                  & (sx >= x_lo) & (sx <= x_hi);

    assign de_fall = de_d & ~pix_de;

    // Shadow registers and row addressing. row_base only advances after a
    // line that actually produced window pixels, so clipped rows/columns
    // never skew the picture; it stops at the last picture row.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            pos_x_s  <= '0;
            pos_y_s  <= '0;
            mode_s   <= MODE_RGB;
            thresh_s <= '0;
            armed    <= 1'b0;
            row_base <= '0;
            row_cnt  <= '0;
            line_hit <= 1'b0;
            de_d     <= 1'b0;
        end else begin
            de_d <= pix_de;
            if (frame_start) begin
                pos_x_s  <= pos_x;
                pos_y_s  <= pos_y;
                mode_s   <= mode_e'(mode);
                thresh_s <= thresh;
                armed    <= 1'b1;
                row_base <= '0;
                row_cnt  <= '0;
                line_hit <= in_win;
            end else if (de_fall) begin
                if (line_hit && (row_cnt < RCW'(PIC_H - 1))) begin
                    row_base <= row_base + ADDR_W'(PIC_W);
                    row_cnt  <= row_cnt + 1'b1;
                end
                line_hit <= 1'b0;
            end else if (in_win) begin
                line_hit <= 1'b1;
            end
        end
    end

    // Stage A: ROM request plus side-band capture
    logic       a_de, a_win;
    mode_e      a_mode;
    logic [7:0] a_thresh;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
            a_de     <= 1'b0;
            a_win    <= 1'b0;
            a_mode   <= MODE_RGB;
            a_thresh <= '0;
        end else begin
            rom_en <= in_win;
            if (in_win)
                rom_addr <= eff_row_base + ADDR_W'(col);
            a_de     <= pix_de;
            a_win    <= in_win;
            a_mode   <= eff_mode;
            a_thresh <= eff_thresh;
        end
    end

    // Side-band delay lines matched to ROM + CSC latency
    logic [D-1:0] de_sr, win_sr;
    mode_e        mode_sr [D];
    logic [7:0]   thr_sr  [D];

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            de_sr  <= '0;
            win_sr <= '0;
            for (int i = 0; i < D; i++) begin
                mode_sr[i] <= MODE_RGB;
                thr_sr[i]  <= '0;
            end
        end else begin
            de_sr      <= {de_sr[D-2:0], a_de};
            win_sr     <= {win_sr[D-2:0], a_win};
            mode_sr[0] <= a_mode;
            thr_sr[0]  <= a_thresh;
            for (int i = 1; i < D; i++) begin
                mode_sr[i] <= mode_sr[i-1];
                thr_sr[i]  <= thr_sr[i-1];
            end
        end
    end

    // ROM pixel delayed to line up with the CSC output
    logic [23:0] rgb_d1, rgb_d2;
    logic [7:0]  y_v, cb_v, cr_v;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rgb_d1 <= '0;
            rgb_d2 <= '0;
        end else begin
            rgb_d1 <= rom_data;
            rgb_d2 <= rgb_d1;
        end
    end

    rgb2ycbcr_pipe u_csc (
        .sys_clk (sys_clk),
        .rst     (rst),
        .rgb     (rom_data),
        .y       (y_v),
        .cb      (cb_v),
        .cr      (cr_v)
    );

    // Goes high on the first clock after reset so the background colour
    // is held off while reset is asserted.
    logic live;

    always_ff @(posedge sys_clk) begin
        if (rst)
            live <= 1'b0;
        else
            live <= 1'b1;
    end

    // Final mux shares the cycle with the CSC sum stage.
    always_comb begin
        pix_data_out = 24'h000000;
        if (win_sr[D-1]) begin
            case (mode_sr[D-1])
                MODE_RGB:  pix_data_out = rgb_d2;
                MODE_GRAY: pix_data_out = {y_v, y_v, y_v};
                MODE_YCC:  pix_data_out = {cr_v, cb_v, y_v};
                MODE_BIN:  pix_data_out = (y_v >= thr_sr[D-1]) ? 24'hFFFFFF : 24'h000000;
                default:   pix_data_out = rgb_d2;
            endcase
        end else if (live) begin
            pix_data_out = BG_COLOR;
        end
    end

    assign pix_de_out = de_sr[D-1];
    assign in_win_out = win_sr[D-1];

endmodule

// File: tb/tb_picture_overlay_csc.sv
// Directed bench for picture_overlay_csc: a default instance (ROM_LAT = 1)
// and a ROM_LAT = 3 instance share the raster inputs, each with a ROM model
// of matching latency that returns a programmable constant pixel.
module tb_picture_overlay_csc;

    localparam logic [23:0] BG   = 24'h00FF00;
    localparam logic [10:0] PARK = 11'd2047;

    logic        sys_clk;
    logic        rst;
    logic        frame_start;
    logic        pix_de;
    logic [10:0] screen_x, screen_y, pos_x, pos_y;
    logic [1:0]  mode;
    logic [7:0]  thresh;

    logic [16:0] rom_addr, rom_addr3;
    logic        rom_en, rom_en3;
    logic [23:0] rom_data  = '0;
    logic [23:0] rom_data3 = '0;
    logic [23:0] r3a = '0, r3b = '0;
    logic [23:0] pix_data_out, pix3;
    logic        pix_de_out, de3, in_win_out, win3;

    logic [23:0] rom_fill = '0;

    int checks = 0;
    int errors = 0;

    logic        mon_on  = 1'b0;
    int          en_cnt  = 0;
    logic [16:0] max_addr = '0;

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    picture_overlay_csc u_dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_de       (pix_de),
        .screen_x     (screen_x),
        .screen_y     (screen_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .mode         (mode),
        .thresh       (thresh),
        .rom_addr     (rom_addr),
        .rom_en       (rom_en),
        .rom_data     (rom_data),
        .pix_data_out (pix_data_out),
        .pix_de_out   (pix_de_out),
        .in_win_out   (in_win_out)
    );

    picture_overlay_csc #(.ROM_LAT(3)) u_dut3 (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .pix_de       (pix_de),
        .screen_x     (screen_x),
        .screen_y     (screen_y),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .mode         (mode),
        .thresh       (thresh),
        .rom_addr     (rom_addr3),
        .rom_en       (rom_en3),
        .rom_data     (rom_data3),
        .pix_data_out (pix3),
        .pix_de_out   (de3),
        .in_win_out   (win3)
    );

    // ROM models
    always @(posedge sys_clk) begin
        if (rom_en) rom_data <= rom_fill;
    end

    always @(posedge sys_clk) begin
        r3a       <= rom_fill;
        r3b       <= r3a;
        rom_data3 <= r3b;
    end

    // Address monitor for the full-frame clip run
    always @(negedge sys_clk) begin
        if (mon_on && rom_en) begin
            en_cnt = en_cnt + 1;
            if (rom_addr > max_addr) max_addr = rom_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame(input logic [10:0] px, input logic [10:0] py,
                               input logic [1:0] m, input logic [7:0] th);
        @(negedge sys_clk);
        pix_de      = 1'b0;
        pos_x       = px;
        pos_y       = py;
        mode        = m;
        thresh      = th;
        frame_start = 1'b1;
        @(negedge sys_clk);
        frame_start = 1'b0;
    endtask

    task automatic end_line();
        @(negedge sys_clk);
        pix_de = 1'b0;
        @(negedge sys_clk);
    endtask

    // One pixel, then parked active pixels; address checked one cycle
    // later, output checked four cycles later.
    task automatic probe(input string tag, input logic [10:0] x, input logic [10:0] y,
                         input logic exp_en, input logic [16:0] exp_addr,
                         input logic exp_win, input logic [23:0] exp_pix);
        @(negedge sys_clk);
        screen_x = x;
        screen_y = y;
        pix_de   = 1'b1;
        @(negedge sys_clk);
        chk({tag, "_en"}, 32'(rom_en), 32'(exp_en));
        if (exp_en) chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        screen_x = PARK;
        repeat (3) @(negedge sys_clk);
        chk({tag, "_de"}, 32'(pix_de_out), 32'd1);
        chk({tag, "_win"}, 32'(in_win_out), 32'(exp_win));
        chk({tag, "_pix"}, 32'(pix_data_out), 32'(exp_pix));
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; pix_de = 1'b0;
        screen_x = '0; screen_y = '0; pos_x = '0; pos_y = '0;
        mode = 2'd0; thresh = '0;

        // reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_en",   32'(rom_en), 32'd0);
        chk("rst_pix",  32'(pix_data_out), 32'd0);
        chk("rst_de",   32'(pix_de_out), 32'd0);
        chk("rst_win",  32'(in_win_out), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("idle_bg", 32'(pix_data_out), 32'(BG));

        // placement, gray mode, red pixel
        rom_fill = 24'h0000FF;
        start_frame(11'd10, 11'd5, 2'd1, 8'd0);
        probe("above", 11'd10, 11'd4, 1'b0, 17'd0, 1'b0, BG);
        end_line();
        probe("left_out",  11'd9,   11'd5, 1'b0, 17'd0,   1'b0, BG);
        probe("first",     11'd10,  11'd5, 1'b1, 17'd0,   1'b1, 24'h4C4C4C);
        probe("last_col",  11'd364, 11'd5, 1'b1, 17'd354, 1'b1, 24'h4C4C4C);
        probe("right_out", 11'd365, 11'd5, 1'b0, 17'd0,   1'b0, BG);
        end_line();
        probe("row1",      11'd10,  11'd6, 1'b1, 17'd355, 1'b1, 24'h4C4C4C);
        probe("row1_c1",   11'd11,  11'd6, 1'b1, 17'd356, 1'b1, 24'h4C4C4C);
        end_line();

        // YCbCr
        start_frame(11'd0, 11'd0, 2'd2, 8'd0);
        rom_fill = 24'hFFFFFF;
        probe("ycc_white", 11'd0, 11'd0, 1'b1, 17'd0, 1'b1, 24'h8080FF);
        rom_fill = 24'hFF0000;
        probe("ycc_blue",  11'd1, 11'd0, 1'b1, 17'd1, 1'b1, 24'h6BFF1C);
        rom_fill = 24'h0000FF;
        probe("ycc_red",   11'd2, 11'd0, 1'b1, 17'd2, 1'b1, 24'hFF554C);
        end_line();

        // binary threshold
        start_frame(11'd0, 11'd0, 2'd3, 8'h80);
        rom_fill = 24'h7F7F7F;
        probe("bin_lo", 11'd0, 11'd0, 1'b1, 17'd0, 1'b1, 24'h000000);
        rom_fill = 24'h808080;
        probe("bin_hi", 11'd1, 11'd0, 1'b1, 17'd1, 1'b1, 24'hFFFFFF);
        end_line();

        // passthrough
        start_frame(11'd20, 11'd30, 2'd0, 8'd0);
        rom_fill = 24'h123456;
        probe("rgb_in",  11'd20, 11'd30, 1'b1, 17'd0, 1'b1, 24'h123456);
        probe("rgb_out", 11'd19, 11'd30, 1'b0, 17'd0, 1'b0, BG);
        end_line();

        // frame_start together with an active pixel at the new position
        rom_fill = 24'h0000FF;
        @(negedge sys_clk);
        pos_x = 11'd100; pos_y = 11'd40; mode = 2'd1;
        frame_start = 1'b1; pix_de = 1'b1;
        screen_x = 11'd100; screen_y = 11'd40;
        @(negedge sys_clk);
        frame_start = 1'b0;
        chk("fs_sim_en",   32'(rom_en), 32'd1);
        chk("fs_sim_addr", 32'(rom_addr), 32'd0);
        screen_x = PARK;
        repeat (3) @(negedge sys_clk);
        chk("fs_sim_pix", 32'(pix_data_out), 32'h4C4C4C);
        end_line();

        // mid-frame changes are ignored until the next frame_start
        start_frame(11'd10, 11'd5, 2'd1, 8'd0);
        probe("mid_a", 11'd10, 11'd5, 1'b1, 17'd0, 1'b1, 24'h4C4C4C);
        @(negedge sys_clk);
        pos_x = 11'd50; mode = 2'd0;
        probe("mid_b", 11'd10, 11'd5, 1'b1, 17'd0,  1'b1, 24'h4C4C4C);
        probe("mid_c", 11'd50, 11'd5, 1'b1, 17'd40, 1'b1, 24'h4C4C4C);
        end_line();
        start_frame(11'd50, 11'd5, 2'd0, 8'd0);
        probe("mid_d", 11'd10, 11'd5, 1'b0, 17'd0, 1'b0, BG);
        probe("mid_e", 11'd50, 11'd5, 1'b1, 17'd0, 1'b1, 24'h0000FF);
        end_line();

        // reset in the middle of a frame
        start_frame(11'd10, 11'd5, 2'd1, 8'd0);
        @(negedge sys_clk);
        screen_x = 11'd10; screen_y = 11'd5; pix_de = 1'b1;
        @(negedge sys_clk);
        screen_x = 11'd11; rst = 1'b1;
        @(negedge sys_clk);
        chk("mrst_addr", 32'(rom_addr), 32'd0);
        chk("mrst_en",   32'(rom_en), 32'd0);
        chk("mrst_pix",  32'(pix_data_out), 32'd0);
        chk("mrst_de",   32'(pix_de_out), 32'd0);
        chk("mrst_win",  32'(in_win_out), 32'd0);
        repeat (2) @(negedge sys_clk);
        rst = 1'b0; screen_x = 11'd12;
        repeat (6) @(negedge sys_clk);
        chk("post_rst_pix", 32'(pix_data_out), 32'(BG));
        chk("post_rst_win", 32'(in_win_out), 32'd0);
        chk("post_rst_de",  32'(pix_de_out), 32'd1);
        chk("post_rst_en",  32'(rom_en), 32'd0);
        probe("post_rst", 11'd10, 11'd5, 1'b0, 17'd0, 1'b0, BG);
        end_line();
        start_frame(11'd10, 11'd5, 2'd1, 8'd0);
        probe("rearm", 11'd10, 11'd5, 1'b1, 17'd0, 1'b1, 24'h4C4C4C);
        end_line();

        // ROM_LAT = 3 instance: latency 6, main instance latency 4
        start_frame(11'd0, 11'd0, 2'd1, 8'd0);
        repeat (8) @(negedge sys_clk);
        screen_x = 11'd0; screen_y = 11'd0; pix_de = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            pix_de = 1'b0;
            chk($sformatf("lat4_de_%0d", k), 32'(pix_de_out), 32'(k == 4));
            chk($sformatf("lat6_de_%0d", k), 32'(de3), 32'(k == 6));
            chk($sformatf("lat6_win_%0d", k), 32'(win3), 32'(k == 6));
            if (k == 4) chk("lat4_pix", 32'(pix_data_out), 32'h4C4C4C);
            if (k == 6) chk("lat6_pix", 32'(pix3), 32'h4C4C4C);
        end

        // right-edge clip over a full picture height on an 800-wide screen
        start_frame(11'd700, 11'd0, 2'd1, 8'd0);
        en_cnt = 0; max_addr = '0; mon_on = 1'b1;
        for (int y = 0; y < 205; y++) begin
            for (int x = 690; x < 800; x++) begin
                @(negedge sys_clk);
                if ((y == 0 || y == 1 || y == 199) && x == 701)
                    chk($sformatf("clip_start_%0d", y), 32'(rom_addr), 32'(y * 355));
                screen_x = 11'(x);
                screen_y = 11'(y);
                pix_de   = 1'b1;
            end
            @(negedge sys_clk);
            if (y == 0 || y == 1 || y == 199)
                chk($sformatf("clip_end_%0d", y), 32'(rom_addr), 32'(y * 355 + 99));
            pix_de = 1'b0;
            @(negedge sys_clk);
        end
        repeat (4) @(negedge sys_clk);
        mon_on = 1'b0;
        chk("clip_en_count", 32'(en_cnt), 32'd20000);
        chk("clip_max_addr", 32'(max_addr), 32'd70744);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/picture_overlay_csc.md
Name: picture_overlay_csc

Overview:
- Parametrised picture-overlay engine for the LCD pixel path.
- Generates ROM read addresses for a PIC_W x PIC_H picture placed at a runtime position, with correct clipping at screen edges.
- Converts the returned RGB888 pixel using one of four frame-latched modes: passthrough, gray, YCbCr, binary threshold.
- Emits a fixed-latency pixel stream with the background colour outside the window.
- Sits between the LCD timing generator (screen_x/screen_y/pix_de) and the LCD output driver; the picture ROM is external.

Parameters:
- PIC_W, 355, picture width in pixels
- PIC_H, 200, picture height in pixels
- X_W, 11, width of the screen/position coordinates
- ADDR_W, 17, ROM address width; must satisfy 2^ADDR_W >= PIC_W*PIC_H
- ROM_LAT, 1, ROM read latency in cycles (rom_en to rom_data valid), range 1..4
- BG_COLOR, 24'h00FF00, colour driven outside the window

Ports:
- sys_clk  in  1  pixel clock; single clock domain
- rst  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame
- pix_de  in  1  active-video qualifier for screen_x/screen_y
- screen_x  in  X_W  current pixel column
- screen_y  in  X_W  current pixel row
- pos_x  in  X_W  picture left column (sampled at frame_start)
- pos_y  in  X_W  picture top row (sampled at frame_start)
- mode  in  2  0 = RGB, 1 = gray, 2 = YCbCr, 3 = binary (sampled at frame_start)
- thresh  in  8  binary-mode luma threshold (sampled at frame_start)
- rom_addr  out  ADDR_W  picture ROM address
- rom_en  out  1  ROM read enable
- rom_data  in  24  ROM pixel: R = [7:0], G = [15:8], B = [23:16]
- pix_data_out  out  24  output pixel
- pix_de_out  out  1  pix_de delayed by L cycles
- in_win_out  out  1  high when pix_data_out carries picture content

Behaviour:
- Latency: L = ROM_LAT + 3 (default 4). Stage breakdown:
  - Stage A: window test and address, 1 cycle.
  - ROM: ROM_LAT cycles.
  - CSC multiply: 1 cycle.
  - Sum/shift/mux: 1 cycle.
- Pipeline alignment: pix_de, the window flag and the latched mode travel through a matched shift register, so each output is aligned with its input pixel.
- Frame latching: on frame_start, pos_x, pos_y, mode and thresh are copied into shadow registers, row_base is cleared to 0, and the armed flag is set. Changing these inputs mid-frame has no effect until the next frame_start.
- Window test:
  - in_win = armed & pix_de & (pos_y_s <= screen_y <= pos_y_s+PIC_H-1) & (pos_x_s <= screen_x <= pos_x_s+PIC_W-1).
  - Both bounds are inclusive.
  - Comparisons are done at X_W+1 bits, so a window extending past the coordinate range does not wrap.
- Address:
  - When in_win: rom_addr <= row_base + (screen_x - pos_x_s) and rom_en <= 1.
  - Otherwise: rom_en <= 0 and rom_addr holds its value.
- Row advance: on a falling edge of pix_de, if any in_win occurred during that line, row_base <= row_base + PIC_W. Clipped rows and columns therefore never skew addressing.
- CSC arithmetic: products are 16-bit unsigned; the Cb/Cr sums are 18-bit signed.
  - Y  = (77R + 150G + 29B) >> 8
  - Cb = (-43R - 85G + 128B + 32768) >> 8, clamped to 0..255
  - Cr = (128R - 107G - 21B + 32768) >> 8, clamped to 0..255
- Output mux when the delayed in_win is 1 (byte order [23:16], [15:8], [7:0]):
  - mode 0: rom_data, delayed to match
  - mode 1: {Y, Y, Y}
  - mode 2: {Cr, Cb, Y}
  - mode 3: Y >= thresh_s gives 24'hFFFFFF, otherwise 24'h000000
- Output when the delayed in_win is 0: pix_data_out = BG_COLOR, whether or not de is active.
- Reset:
  - All outputs go to 0 (rom_addr, rom_en, pix_data_out, pix_de_out, in_win_out).
  - Pipeline, row_base, shadow registers and armed are cleared.
  - Reset mid-frame flushes in-flight pixels.
  - The window stays disabled (BG_COLOR on active pixels) until the next frame_start.
- Simultaneous frame_start and pix_de: frame_start takes effect first, so that pixel uses the new shadow values.
- Address bound: rom_addr never exceeds PIC_W*PIC_H-1 within a frame. row_base stops advancing after PIC_H window rows.

Decomposition:
- Shared package (lcd_pkg):
  - mode enum: MODE_RGB, MODE_GRAY, MODE_YCC, MODE_BIN
  - CSC coefficient constants and the Cb/Cr offset 32768
  - pixel byte-lane localparams
- Sub-module rgb2ycbcr_pipe:
  - Two-stage pipelined CSC.
  - Inputs: 24-bit RGB. Outputs: Y, Cb, Cr.
  - Fixed latency of 2; reused elsewhere in the codebase.
- Top level: window/address logic, delay lines and the output mux.

Test Plan:
- Reset behaviour: assert rst for 3 cycles mid-frame -> all outputs 0 next cycle; BG_COLOR 24'h00FF00 on active pixels until the next frame_start.
- Placement, mode 1: pos = (10, 5), ROM returns R = 255, G = 0, B = 0 -> rom_addr = 0 at (10, 5) and 355 at (10, 6); last window pixel (364, 5) gives rom_addr = 354; pix_data_out = 24'h4C4C4C at the input time +4 cycles; (9, 5) and (365, 5) give 24'h00FF00.
- Mode 2, white pixel R = G = B = 255 -> {Cr, Cb, Y} = 24'h80_80_FF; pure blue B = 255 -> Cb = 8'hFF.
- Mode 3, thresh = 8'h80: gray 8'h7F -> 24'h000000; gray 8'h80 -> 24'hFFFFFF.
- Right-edge clip on an 800-wide screen, pos_x = 700: row N addresses 0..99, row N+1 starts at 355; no address exceeds 70999 over a full frame.
- Mid-frame change of pos_x/mode -> current frame unchanged; change applies from the next frame_start. Set ROM_LAT = 3 -> latency becomes 6 cycles with pix_de_out still aligned.
